// File: rtl/clk_rst_pkg.sv
// Shared types and defaults for the clock-wizard reset/lock supervisor.
// Holds the state encoding, default timing constants and the timer-width helper.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4
  } state_e;

  localparam int unsigned DefPllRstCycles = 16;
  localparam int unsigned DefLockTimeout  = 4096;
  localparam int unsigned DefStableCycles = 1024;
  localparam int unsigned DefNumStages    = 3;
  localparam int unsigned DefStageGap     = 16;
  localparam int unsigned DefCntW         = 8;

  // Wide enough to hold the largest timing parameter with a bit of headroom.
  function automatic int unsigned timer_width(input int unsigned pll_rst_cycles,
                                              input int unsigned lock_timeout,
                                              input int unsigned stable_cycles,
                                              input int unsigned stage_gap);
    int unsigned max_v;
    max_v = pll_rst_cycles;
    if (lock_timeout > max_v) max_v = lock_timeout;
    if (stable_cycles > max_v) max_v = stable_cycles;
    if (stage_gap > max_v) max_v = stage_gap;
    return $clog2(max_v) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_rst_ctrl.sv
// Reset/lock supervisor for a clock wizard: pulses the PLL reset, qualifies lock,
// then releases staged active-low resets in order and tears them down on lock loss.
module clk_rst_ctrl
  import clk_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT   = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES  = DefStableCycles,
  parameter int unsigned NUM_STAGES     = DefNumStages,
  parameter int unsigned STAGE_GAP      = DefStageGap,
  parameter int unsigned CNT_W          = DefCntW
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  pll_locked,
  input  logic                  clr_err,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  sys_ready,
  output logic                  lock_err,
  output logic [CNT_W-1:0]      loss_cnt,
  output logic [2:0]            fsm_state
);

  localparam int unsigned TmrW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                             STAGE_GAP);
  localparam int unsigned StgW = 4;

  typedef logic [TmrW-1:0] tmr_t;
  typedef logic [StgW-1:0] stg_t;

  localparam tmr_t PllRstLast  = tmr_t'(PLL_RST_CYCLES - 1);
  localparam tmr_t TimeoutLast = tmr_t'(LOCK_TIMEOUT - 1);
  localparam tmr_t StableLast  = tmr_t'(STABLE_CYCLES - 1);
  localparam tmr_t GapLast     = tmr_t'(STAGE_GAP - 1);
  localparam stg_t StgAll      = stg_t'(NUM_STAGES);

  logic locked_s;

  state_e                state_q, state_d;
  tmr_t                  timer_q, timer_d;
  stg_t                  stage_q, stage_d;
  logic                  pll_rst_q, pll_rst_d;
  logic [NUM_STAGES-1:0] rst_n_out_q, rst_n_out_d;
  logic                  sys_ready_q, sys_ready_d;
  logic                  lock_err_q, lock_err_d;
  logic [CNT_W-1:0]      loss_cnt_q, loss_cnt_d;
  logic                  lock_err_set;
  logic                  loss_inc;
  logic                  release_now;

  sync_2ff u_lock_sync (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 1'b1;
    stage_d      = stage_q;
    rst_n_out_d  = rst_n_out_q;
    lock_err_d   = lock_err_q;
    loss_cnt_d   = loss_cnt_q;
    lock_err_set = 1'b0;
    loss_inc     = 1'b0;
    release_now  = 1'b0;

    unique case (state_q)
      StPllRst: begin
        if (timer_q == PllRstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStable;
        end else if (timer_q == TimeoutLast) begin
          state_d      = StPllRst;
          lock_err_set = 1'b1;
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (timer_q == StableLast) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!locked_s) begin
          state_d  = StPllRst;
          loss_inc = 1'b1;
        end else if (stage_q == '0) begin
          // First edge spent in RELEASE frees stage 0 without waiting a gap.
          release_now = 1'b1;
        end else if (timer_q == GapLast) begin
          if (stage_q == StgAll) state_d = StRun;
          else release_now = 1'b1;
        end
      end
      StRun: begin
        timer_d = '0;
        if (!locked_s) begin
          state_d  = StPllRst;
          loss_inc = 1'b1;
        end
      end
      default: state_d = StPllRst;
    endcase

    if (release_now) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        if (stage_q == stg_t'(i)) rst_n_out_d[i] = 1'b1;
      end
      stage_d = stage_q + 1'b1;
      timer_d = '0;
    end

    if (state_d != state_q) timer_d = '0;

    // Stage resets may only be released while sequencing or running.
    if (state_d != StRelease && state_d != StRun) begin
      rst_n_out_d = '0;
      stage_d     = '0;
    end

    pll_rst_d   = (state_d == StPllRst);
    sys_ready_d = (state_d == StRun);

    if (clr_err) begin
      lock_err_d = 1'b0;
      loss_cnt_d = '0;
    end else begin
      if (lock_err_set) lock_err_d = 1'b1;
      if (loss_inc && loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StPllRst;
      timer_q     <= '0;
      stage_q     <= '0;
      pll_rst_q   <= 1'b1;
      rst_n_out_q <= '0;
      sys_ready_q <= 1'b0;
      lock_err_q  <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stage_q     <= stage_d;
      pll_rst_q   <= pll_rst_d;
      rst_n_out_q <= rst_n_out_d;
      sys_ready_q <= sys_ready_d;
      lock_err_q  <= lock_err_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_n_out = rst_n_out_q;
  assign sys_ready = sys_ready_q;
  assign lock_err  = lock_err_q;
  assign loss_cnt  = loss_cnt_q;
  assign fsm_state = state_q;

endmodule

// File: doc/clk_rst_ctrl.md
Name: clk_rst_ctrl

Overview:
Reset/lock supervisor that sits beside the clocking wizard.
- Drives the wizard's active-high reset input.
- Monitors the wizard's asynchronous locked output.
- Once lock is proven stable, releases active-low resets to downstream logic in a fixed stage order.
- Tears all stage resets down again on lock loss and restarts the PLL.
- Runs entirely on the board input clock, so it stays alive while the PLL is unlocked.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset attempt (min 1)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before a retry (min 1)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (min 1)
NUM_STAGES, 3, number of sequenced reset outputs (1..8)
STAGE_GAP, 16, cycles between successive stage releases (min 1)
CNT_W, 8, width of the lock-loss event counter

Ports:
sys_clk  input  1  board clock; all state is clocked on its rising edge
sys_rst_n  input  1  asynchronous active-low reset
pll_locked  input  1  wizard locked output; asynchronous to sys_clk
clr_err  input  1  synchronous pulse; clears lock_err and loss_cnt
pll_rst  output  1  active-high reset to the clock wizard
rst_n_out  output  NUM_STAGES  active-low stage resets; bit 0 is released first
sys_ready  output  1  high only in RUN
lock_err  output  1  sticky flag; set on any WAIT_LOCK timeout
loss_cnt  output  CNT_W  saturating count of lock losses seen in RELEASE or RUN
fsm_state  output  3  current state encoding, for debug

Behaviour:
- Reset values while sys_rst_n is low: pll_rst=1, rst_n_out=0, sys_ready=0, lock_err=0, loss_cnt=0, synchronizer flops=0, state=PLL_RST, counters=0. Reset takes effect asynchronously at any point, mid-operation included.
- pll_locked passes through a 2-flop synchronizer giving locked_s. All decisions below use locked_s, which lags pll_locked by 2 sys_clk edges.
- One shared down/up timer is cleared on every state transition. Its width is $clog2 of the largest timing parameter plus 1.
- PLL_RST:
  - pll_rst=1.
  - After PLL_RST_CYCLES cycles in this state, go to WAIT_LOCK.
  - After reset release, pll_rst therefore stays high for exactly PLL_RST_CYCLES edges.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Else if the timer reaches LOCK_TIMEOUT, set lock_err=1 and go to PLL_RST.
- STABLE:
  - Timer counts while locked_s=1.
  - If locked_s=0, go to WAIT_LOCK with a fresh timeout. This is not counted as a loss.
  - After STABLE_CYCLES consecutive high cycles, go to RELEASE.
- RELEASE:
  - rst_n_out[0] goes high on the first edge in RELEASE.
  - rst_n_out[k] goes high exactly STAGE_GAP cycles after rst_n_out[k-1].
  - Released bits stay high.
  - STAGE_GAP cycles after the last bit is released, go to RUN.
- RUN: sys_ready=1. All rst_n_out bits are high.
- Lock loss (locked_s=0 in RELEASE or RUN):
  - On the next edge, all rst_n_out bits go low together, sys_ready=0, pll_rst=1, state=PLL_RST.
  - loss_cnt increments, saturating at all-ones.
- clr_err=1 clears lock_err and loss_cnt to 0 on that edge.
  - Clear has priority over a same-cycle set or increment; that event is dropped.
- Outputs other than fsm_state are registered. No output ever glitches combinationally.
- rst_n_out never releases out of order. It never releases while pll_rst=1 or outside RELEASE/RUN.
- Encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.

Decomposition:
- Shared package clk_rst_pkg holds:
  - the state enum/localparams (3-bit encoding above);
  - default timing constants;
  - a function that computes the timer width from the parameters.
- One sub-module: sync_2ff, a single-bit 2-flop synchronizer with async active-low reset to 0, used for pll_locked.
- FSM, timer, stage pointer and counters live in clk_rst_ctrl.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, NUM_STAGES=3, STAGE_GAP=5, and a 10 ns sys_clk.
1. Normal bring-up:
   - Stimulus: release sys_rst_n, then raise pll_locked 10 cycles later and hold it.
   - Required response: pll_rst high for 4 edges. rst_n_out goes 001, then 011 five cycles later, then 111 five cycles after that. sys_ready rises 5 cycles after 111. lock_err=0.
2. Lock timeout:
   - Stimulus: keep pll_locked=0.
   - Required response: pll_rst re-pulses for 4 cycles every 24 cycles (4 + 20). lock_err=1 after the first timeout. rst_n_out stays 000.
3. Unstable lock:
   - Stimulus: pll_locked high for 5 cycles, low for 2, then steady high.
   - Required response: no release during the glitch; release begins 8 cycles after locked_s is steady. loss_cnt=0.
4. Lock loss in RUN:
   - Stimulus: from RUN, drop pll_locked.
   - Required response: 3 edges later (2 synchronizer + 1), rst_n_out=000, sys_ready=0, pll_rst=1, loss_cnt=1.
   - Then re-lock; sequencing repeats and loss_cnt stays 1.
5. Counter saturation and clear:
   - Stimulus: with CNT_W=2, cause 5 losses, then pulse clr_err on the same cycle as a 6th loss.
   - Required response: loss_cnt reads 3 after the 3rd loss and holds 3. After the clear it is 0, and lock_err is 0.
6. Async reset mid-RELEASE:
   - Stimulus: assert sys_rst_n low while rst_n_out=011.
   - Required response: all outputs return to their reset values immediately, without waiting for a clock edge.
